panel_btn_cond: RTL and testbench

Front-panel button conditioner that sits directly upstream of the TOY system top. It takes the seven raw pushbutton inputs (LOAD, LOOK, STEP, RUN, ENTER, STOP, RESET) and runs each through a synchronizer and a debouncer. It then produces clean debounced levels, arbitrated single-cycle press pulses (at most one per clock) and per-button LED drive. The pulses feed the system top's btn_*_i inputs; the LED outputs feed the panel lamps.

---
 rtl/panel_btn_cond_if.sv | 27 ++
 rtl/panel_btn_cond.sv | 220 ++++++++++++++++++++++
 tb/tb_panel_btn_cond.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/panel_btn_cond_if.sv
// Front-panel button bundle between the raw panel pins and the conditioner outputs.
// master: panel/board side. It drives the raw pins and consumes levels, pulses, lamps and busy.
// slave : the conditioner. It samples the raw pins and drives everything else.
interface panel_btn_cond_if;
    // bit0 LOAD, bit1 LOOK, bit2 STEP, bit3 RUN, bit4 ENTER, bit5 STOP, bit6 RESET
    logic [6:0] btn_raw_i;
    logic [6:0] btn_level_o;
    logic [6:0] btn_pulse_o;
    logic [6:0] btn_led_o;
    logic       busy_o;

    modport master (
        output btn_raw_i,
        input  btn_level_o,
        input  btn_pulse_o,
        input  btn_led_o,
        input  busy_o
    );

    modport slave (
        input  btn_raw_i,
        output btn_level_o,
        output btn_pulse_o,
        output btn_led_o,
        output busy_o
    );
endinterface

// File: rtl/panel_btn_cond.sv
// Purpose: sync + debounce seven panel buttons, emit one arbitrated press pulse per clock and lamp drive.
// Latency: raw change -> btn_level_o after DEBOUNCE_CYCLES+2 edges, -> btn_pulse_o one edge later.
// Backpressure: none; losing press/repeat requests in a cycle are dropped, never queued.
//
// Ports: clk, rst_n (async, active-low), bus (panel_btn_cond_if.slave):
//   btn_raw_i in 7, btn_level_o out 7, btn_pulse_o out 7 (0 or one-hot), btn_led_o out 7, busy_o out 1.
// Optional macro PANEL_REPEAT_EN: STEP/LOOK auto-repeat while held (REPEAT_DELAY, then every REPEAT_PERIOD).
module panel_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter bit RAW_ACTIVE_LOW  = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic            clk,
    input  logic            rst_n,
    panel_btn_cond_if.slave bus
);

    localparam int N = 7;

    // Button bit positions
    localparam int B_LOAD  = 0;
    localparam int B_LOOK  = 1;
    localparam int B_STEP  = 2;
    localparam int B_RUN   = 3;
    localparam int B_ENTER = 4;
    localparam int B_STOP  = 5;
    localparam int B_RESET = 6;

    logic [N-1:0]     sync1_q, sync1_d;
    logic [N-1:0]     sync2_q, sync2_d;
    logic [N-1:0]     stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [N-1:0]     armed_q, armed_d;
    logic [1:0]       sync_vld_q, sync_vld_d;
    logic [N-1:0]     pulse_q, pulse_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     press_req;
    logic [N-1:0]     rpt_req;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;

    // ------------------------------------------------------------------
    // Input stage and per-bit debounce
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d  = bus.btn_raw_i ^ {N{RAW_ACTIVE_LOW}};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        busy_d   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            // busy_q then tracks the counters in the same cycle they are nonzero
            busy_d = busy_d | (cnt_d[i] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Arming: a press request needs a prior observed release. The sync
    // pipeline holds zeros for two edges after reset, so arming waits until
    // it carries real pin values; otherwise a button held through reset
    // would look released and fire on its first debounce.
    // ------------------------------------------------------------------
    always_comb begin
        sync_vld_d = sync_vld_q;
        if (sync_vld_q != 2'd2) begin
            sync_vld_d = sync_vld_q + 2'd1;
        end

        press_req = stable_q & armed_q;
        // A request consumes the arm whether or not it wins arbitration.
        armed_d   = armed_q & ~press_req;
        if (sync_vld_q == 2'd2) begin
            armed_d = armed_d | (~stable_q & ~sync2_q);
        end
    end

    // ------------------------------------------------------------------
    // Fixed-priority arbiter: RESET > STOP > LOAD > LOOK > STEP > RUN > ENTER
    // ------------------------------------------------------------------
    always_comb begin
        req   = press_req | rpt_req;
        grant = '0;
        if (req[B_RESET]) begin
            grant[B_RESET] = 1'b1;
        end else if (req[B_STOP]) begin
            grant[B_STOP] = 1'b1;
        end else if (req[B_LOAD]) begin
            grant[B_LOAD] = 1'b1;
        end else if (req[B_LOOK]) begin
            grant[B_LOOK] = 1'b1;
        end else if (req[B_STEP]) begin
            grant[B_STEP] = 1'b1;
        end else if (req[B_RUN]) begin
            grant[B_RUN] = 1'b1;
        end else if (req[B_ENTER]) begin
            grant[B_ENTER] = 1'b1;
        end
        pulse_d = grant;
    end

`ifdef PANEL_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat for LOOK (timer 0) and STEP (timer 1). A timer starts at
    // cnt=1 in the cycle its press pulse is visible, so a match at
    // cnt==REPEAT_DELAY lands the repeat pulse exactly REPEAT_DELAY cycles
    // after the press pulse; later repeats count REPEAT_PERIOD the same way.
    // ------------------------------------------------------------------
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [1:0]       rpt_act_q, rpt_act_d;
    logic [1:0]       rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0] rpt_cnt_q [2];
    logic [RPT_W-1:0] rpt_cnt_d [2];

    always_comb begin
        rpt_req = '0;
        for (int j = 0; j < 2; j++) begin
            if (rpt_act_q[j] && stable_q[B_LOOK + j] &&
                (rpt_cnt_q[j] == (rpt_first_q[j] ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD)))) begin
                rpt_req[B_LOOK + j] = 1'b1;
            end
        end
    end

    always_comb begin
        rpt_act_d   = rpt_act_q;
        rpt_first_d = rpt_first_q;
        for (int j = 0; j < 2; j++) begin
            rpt_cnt_d[j] = rpt_cnt_q[j];
            if (!stable_q[B_LOOK + j]) begin
                rpt_act_d[j]   = 1'b0;
                rpt_first_d[j] = 1'b0;
                rpt_cnt_d[j]   = '0;
            end else if (grant[B_LOOK + j] && press_req[B_LOOK + j]) begin
                rpt_act_d[j]   = 1'b1;
                rpt_first_d[j] = 1'b1;
                rpt_cnt_d[j]   = RPT_W'(1);
            end else if (rpt_req[B_LOOK + j]) begin
                // Restart the period whether or not this repeat won.
                rpt_first_d[j] = 1'b0;
                rpt_cnt_d[j]   = RPT_W'(1);
            end else if (rpt_act_q[j]) begin
                rpt_cnt_d[j] = rpt_cnt_q[j] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_act_q   <= '0;
            rpt_first_q <= '0;
            for (int j = 0; j < 2; j++) begin
                rpt_cnt_q[j] <= '0;
            end
        end else begin
            rpt_act_q   <= rpt_act_d;
            rpt_first_q <= rpt_first_d;
            for (int j = 0; j < 2; j++) begin
                rpt_cnt_q[j] <= rpt_cnt_d[j];
            end
        end
    end
`else
    assign rpt_req = '0;

    // Repeat timing parameters only matter when auto-repeat is built in.
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            armed_q    <= '0;
            sync_vld_q <= '0;
            pulse_q    <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            armed_q    <= armed_d;
            sync_vld_q <= sync_vld_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The RESET lamp is hard-wired on.
    // ------------------------------------------------------------------
    assign bus.btn_level_o = stable_q;
    assign bus.btn_pulse_o = pulse_q;
    assign bus.btn_led_o   = {1'b1, stable_q[B_STOP:B_LOAD]};
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_panel_btn_cond.sv
// Bench for panel_btn_cond with DEBOUNCE_CYCLES=4. Expected press pulses (cycle, value) are queued when
// stimulus is driven; a negedge monitor pops and compares every nonzero pulse and flags overdue ones.
module tb_panel_btn_cond;

    localparam int DC = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } exp_t;

    exp_t exp_q[$];

    panel_btn_cond_if bus_if ();

    panel_btn_cond #(
        .DEBOUNCE_CYCLES(DC),
        .RAW_ACTIVE_LOW (1'b0),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: expected %b at cycle %0d, not observed by cycle %0d", e.val, e.cyc, cyc);
        end
        if (bus_if.btn_pulse_o !== 7'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, required none", bus_if.btn_pulse_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus_if.btn_pulse_o !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                             bus_if.btn_pulse_o, cyc, e.val, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int at, input logic [6:0] val);
        exp_t e;
        e.cyc = at;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus_if.btn_raw_i = 7'b0;
        tick(2);
        checks++;
        if (bus_if.btn_level_o !== 7'b0 || bus_if.btn_pulse_o !== 7'b0 ||
            bus_if.btn_led_o !== 7'b1000000 || bus_if.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: level=%b pulse=%b led=%b busy=%b, required 0/0/1000000/0",
                     bus_if.btn_level_o, bus_if.btn_pulse_o, bus_if.btn_led_o, bus_if.busy_o);
        end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_press_step;
        bus_if.btn_raw_i[2] = 1'b1;
        expect_pulse(cyc + DC + 3, 7'b0000100);
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            checks++;
            if (bus_if.btn_level_o[2] !== (k >= DC + 2)) begin
                errors++;
                $display("FAIL step_level edge %0d: got %b, required %b", k, bus_if.btn_level_o[2], (k >= DC + 2));
            end
        end
        checks++;
        if (bus_if.btn_led_o !== 7'b1000100) begin
            errors++;
            $display("FAIL step_led: got %b, required 1000100", bus_if.btn_led_o);
        end
        bus_if.btn_raw_i[2] = 1'b0;
        tick(12);
        checks++;
        if (bus_if.btn_level_o !== 7'b0 || bus_if.btn_led_o !== 7'b1000000) begin
            errors++;
            $display("FAIL step_release: level=%b led=%b, required 0 / 1000000", bus_if.btn_level_o, bus_if.btn_led_o);
        end
    endtask

    task automatic test_glitch;
        bit busy_seen;
        busy_seen = 1'b0;
        // DC-1 cycles high: rejected
        bus_if.btn_raw_i[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (k == DC - 1) bus_if.btn_raw_i[0] = 1'b0;
            if (bus_if.busy_o === 1'b1) busy_seen = 1'b1;
            checks++;
            if (bus_if.btn_level_o !== 7'b0) begin
                errors++;
                $display("FAIL glitch_level edge %0d: got %b, required 0", k, bus_if.btn_level_o);
            end
        end
        checks++;
        if (busy_seen !== 1'b1 || bus_if.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: seen=%b final=%b, required 1 then 0", busy_seen, bus_if.busy_o);
        end
        // exactly DC cycles high: accepted as a press
        bus_if.btn_raw_i[0] = 1'b1;
        expect_pulse(cyc + DC + 3, 7'b0000001);
        tick(DC);
        bus_if.btn_raw_i[0] = 1'b0;
        tick(3);
        checks++;
        if (bus_if.btn_level_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL boundary_level: got %b, required 1", bus_if.btn_level_o[0]);
        end
        tick(12);
        checks++;
        if (bus_if.btn_level_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL boundary_release: got %b, required 0", bus_if.btn_level_o[0]);
        end
    endtask

    task automatic test_same_edge;
        bus_if.btn_raw_i[0] = 1'b1;
        bus_if.btn_raw_i[5] = 1'b1;
        expect_pulse(cyc + DC + 3, 7'b0100000);
        tick(20);
        checks++;
        if (bus_if.btn_level_o !== 7'b0100001) begin
            errors++;
            $display("FAIL same_edge_level: got %b, required 0100001", bus_if.btn_level_o);
        end
        bus_if.btn_raw_i[0] = 1'b0;
        bus_if.btn_raw_i[5] = 1'b0;
        tick(14);
    endtask

    task automatic test_hold_thru_reset;
        rst_n = 1'b0;
        bus_if.btn_raw_i[3] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            checks++;
            if (bus_if.btn_level_o[3] !== (k >= DC + 2)) begin
                errors++;
                $display("FAIL held_level edge %0d: got %b, required %b", k, bus_if.btn_level_o[3], (k >= DC + 2));
            end
        end
        bus_if.btn_raw_i[3] = 1'b0;
        tick(12);
        bus_if.btn_raw_i[3] = 1'b1;
        expect_pulse(cyc + DC + 3, 7'b0001000);
        tick(14);
        bus_if.btn_raw_i[3] = 1'b0;
        tick(12);
    endtask

    task automatic test_reset_mid;
        bus_if.btn_raw_i[4] = 1'b1;
        tick(3);
        checks++;
        if (bus_if.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b, required 1", bus_if.busy_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.btn_level_o !== 7'b0 || bus_if.btn_pulse_o !== 7'b0 ||
            bus_if.btn_led_o !== 7'b1000000 || bus_if.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: level=%b pulse=%b led=%b busy=%b, required 0/0/1000000/0",
                     bus_if.btn_level_o, bus_if.btn_pulse_o, bus_if.btn_led_o, bus_if.busy_o);
        end
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            checks++;
            if (bus_if.btn_level_o[4] !== (k >= DC + 2)) begin
                errors++;
                $display("FAIL restart_level edge %0d: got %b, required %b", k, bus_if.btn_level_o[4], (k >= DC + 2));
            end
        end
        bus_if.btn_raw_i[4] = 1'b0;
        tick(12);
        bus_if.btn_raw_i[4] = 1'b1;
        expect_pulse(cyc + DC + 3, 7'b0010000);
        tick(12);
        bus_if.btn_raw_i[4] = 1'b0;
        tick(12);
    endtask

`ifdef PANEL_REPEAT_EN
    task automatic test_repeat;
        int p;
        bus_if.btn_raw_i[2] = 1'b1;
        p = cyc + DC + 3;
        expect_pulse(p, 7'b0000100);
        expect_pulse(p + 20, 7'b0000100);
        expect_pulse(p + 28, 7'b0000100);
        expect_pulse(p + 36, 7'b0000100);
        tick(40);
        bus_if.btn_raw_i[2] = 1'b0;
        tick(40);
    endtask
`endif

    task automatic test_drain;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected pulses outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_press_step();
        test_glitch();
        test_same_edge();
        test_hold_thru_reset();
        test_reset_mid();
`ifdef PANEL_REPEAT_EN
        test_repeat();
`endif
        tick(4);
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
